vga_timing_gen: RTL

Parametrised VGA raster timing generator that replaces the fixed 640x480 controller. It derives a pixel tick from the system clock and runs horizontal and vertical counters. From these it produces sync pulses of configurable polarity, an active-video flag, and zero-based pixel coordinates. It also emits start-of-frame, start-of-line and vertical-blank strobes that the sprite/pipe renderers and game-state logic use to schedule their per-frame updates.

---
 rtl/vga_timing_pkg.sv | 52 +++++
 rtl/pix_tick_div.sv | 41 ++++
 rtl/vga_timing_gen.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/vga_timing_pkg.sv
// -----------------------------------------------------------------------------
// vga_timing_pkg
// Shared raster-mode constants for the VGA timing generator and its users.
//   vga_mode_t       : porch/sync/active geometry plus sync polarities
//   MODE_640X480_60  : 25 MHz-class pixel clock, negative syncs
//   MODE_800X600_60  : 40 MHz pixel clock, positive syncs
//   min_cw()         : smallest counter width holding H_TOTAL-1 and V_TOTAL-1
// -----------------------------------------------------------------------------
package vga_timing_pkg;

    typedef struct packed {
        logic [15:0] h_active;
        logic [15:0] h_fp;
        logic [15:0] h_sync;
        logic [15:0] h_bp;
        logic [15:0] v_active;
        logic [15:0] v_fp;
        logic [15:0] v_sync;
        logic [15:0] v_bp;
        logic        hs_neg;
        logic        vs_neg;
    } vga_mode_t;

    localparam vga_mode_t MODE_640X480_60 = '{
        h_active: 16'd640, h_fp: 16'd16, h_sync: 16'd96,  h_bp: 16'd48,
        v_active: 16'd480, v_fp: 16'd10, v_sync: 16'd2,   v_bp: 16'd33,
        hs_neg:   1'b1,    vs_neg: 1'b1
    };

    localparam vga_mode_t MODE_800X600_60 = '{
        h_active: 16'd800, h_fp: 16'd40, h_sync: 16'd128, h_bp: 16'd88,
        v_active: 16'd600, v_fp: 16'd1,  v_sync: 16'd4,   v_bp: 16'd23,
        hs_neg:   1'b0,    vs_neg: 1'b0
    };

    // Bits needed so that the larger of H_TOTAL-1 / V_TOTAL-1 is representable.
    function automatic int min_cw(input vga_mode_t m);
        int h_total;
        int v_total;
        int top;
        int w;
        h_total = int'(m.h_active) + int'(m.h_fp) + int'(m.h_sync) + int'(m.h_bp);
        v_total = int'(m.v_active) + int'(m.v_fp) + int'(m.v_sync) + int'(m.v_bp);
        top     = (h_total > v_total) ? (h_total - 32'sd1) : (v_total - 32'sd1);
        w       = 32'sd1;
        while ((32'sd1 << w) <= top) begin
            w = w + 32'sd1;
        end
        return w;
    endfunction

endpackage

// File: rtl/pix_tick_div.sv
// -----------------------------------------------------------------------------
// pix_tick_div
// Divides the system clock down to a one-clk tick every DIV enabled clocks.
//   clk  : system clock
//   clr  : asynchronous reset, active-high
//   en   : run enable; 0 freezes the divider
//   tick : combinational strobe, high in the clk where the divider is at DIV-1
// With DIV=1 the counter never leaves 0 and tick simply follows en.
// -----------------------------------------------------------------------------
module pix_tick_div #(
    parameter int DIV = 32'sd2
) (
    input  logic clk,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int            DW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [DW-1:0] LAST = DW'(DIV - 1);

    logic [DW-1:0] div_cnt_r;

    // Divider counter: 0..DIV-1, advancing only while enabled.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            div_cnt_r <= '0;
        end else if (en) begin
            if (div_cnt_r == LAST) begin
                div_cnt_r <= '0;
            end else begin
                div_cnt_r <= div_cnt_r + DW'(1);
            end
        end else begin
            div_cnt_r <= div_cnt_r;
        end
    end

    assign tick = en && (div_cnt_r == LAST);

endmodule

// File: rtl/vga_timing_gen.sv
// -----------------------------------------------------------------------------
// vga_timing_gen
// Parametrised VGA raster timing generator.
//   clk      : system clock
//   clr      : asynchronous reset, active-high
//   en       : run enable; 0 freezes divider, counters and outputs
//   pix_tick : one-clk strobe per pixel period (not delayed)
//   vga_HS   : horizontal sync at configured polarity (registered)
//   vga_VS   : vertical sync at configured polarity (registered)
//   display  : active-region flag (registered)
//   X, Y     : zero-based active coordinates, 0 outside the active region
//   sof      : start-of-frame strobe, first clk of count (0,0)
//   sol      : start-of-active-line strobe, first clk of h=0 on active lines
//   vblank   : high while v_cnt >= V_ACTIVE
// All registered outputs lag the counters by one clk.
// -----------------------------------------------------------------------------
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE = int'(MODE_640X480_60.h_active),
    parameter int H_FP     = int'(MODE_640X480_60.h_fp),
    parameter int H_SYNC   = int'(MODE_640X480_60.h_sync),
    parameter int H_BP     = int'(MODE_640X480_60.h_bp),
    parameter int V_ACTIVE = int'(MODE_640X480_60.v_active),
    parameter int V_FP     = int'(MODE_640X480_60.v_fp),
    parameter int V_SYNC   = int'(MODE_640X480_60.v_sync),
    parameter int V_BP     = int'(MODE_640X480_60.v_bp),
    parameter int HS_NEG   = int'(MODE_640X480_60.hs_neg),
    parameter int VS_NEG   = int'(MODE_640X480_60.vs_neg),
    parameter int PIX_DIV  = 32'sd2,
    parameter int CW       = 32'sd11
) (
    input  logic          clk,
    input  logic          clr,
    input  logic          en,
    output logic          pix_tick,
    output logic          vga_HS,
    output logic          vga_VS,
    output logic          display,
    output logic [CW-1:0] X,
    output logic [CW-1:0] Y,
    output logic          sof,
    output logic          sol,
    output logic          vblank
);

    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HS_START = H_ACTIVE + H_FP;
    localparam int HS_END   = HS_START + H_SYNC;
    localparam int VS_START = V_ACTIVE + V_FP;
    localparam int VS_END   = VS_START + V_SYNC;

    localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);
    localparam logic          HS_POL = (HS_NEG != 0);
    localparam logic          VS_POL = (VS_NEG != 0);

    logic          tick_s;
    logic [CW-1:0] h_cnt_r;
    logic [CW-1:0] v_cnt_r;
    // Set when the current count has just been loaded and no enabled clk has
    // yet consumed it; this is what makes the strobes single-shot.
    logic          fresh_r;

    logic          hs_act_s;
    logic          vs_act_s;
    logic          act_s;
    logic          sof_s;
    logic          sol_s;
    logic [CW-1:0] x_s;
    logic [CW-1:0] y_s;

    pix_tick_div #(
        .DIV (PIX_DIV)
    ) u_div (
        .clk  (clk),
        .clr  (clr),
        .en   (en),
        .tick (tick_s)
    );

    assign pix_tick = tick_s;

    // Horizontal/vertical raster counters, advanced once per pixel tick.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            h_cnt_r <= '0;
            v_cnt_r <= '0;
        end else if (tick_s) begin
            if (h_cnt_r == H_LAST) begin
                h_cnt_r <= '0;
                if (v_cnt_r == V_LAST) begin
                    v_cnt_r <= '0;
                end else begin
                    v_cnt_r <= v_cnt_r + CW'(1);
                end
            end else begin
                h_cnt_r <= h_cnt_r + CW'(1);
                v_cnt_r <= v_cnt_r;
            end
        end else begin
            h_cnt_r <= h_cnt_r;
            v_cnt_r <= v_cnt_r;
        end
    end

    // Freshness flag: armed by reset or by a count load, cleared by the first
    // enabled clk that sees the count; frozen while en=0.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            fresh_r <= 1'b1;
        end else if (en) begin
            fresh_r <= tick_s;
        end else begin
            fresh_r <= fresh_r;
        end
    end

    // Region decode from the current counter values.
    always_comb begin
        hs_act_s = (h_cnt_r >= CW'(HS_START)) && ({1'b0, h_cnt_r} < (CW+1)'(HS_END));
        vs_act_s = (v_cnt_r >= CW'(VS_START)) && ({1'b0, v_cnt_r} < (CW+1)'(VS_END));
        act_s    = (h_cnt_r < CW'(H_ACTIVE)) && (v_cnt_r < CW'(V_ACTIVE));
        sof_s    = fresh_r && (h_cnt_r == '0) && (v_cnt_r == '0);
        sol_s    = fresh_r && (h_cnt_r == '0) && (v_cnt_r < CW'(V_ACTIVE));
        if (act_s) begin
            x_s = h_cnt_r;
            y_s = v_cnt_r;
        end else begin
            x_s = '0;
            y_s = '0;
        end
    end

    // Output register: levels hold and strobes drop while frozen.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            vga_HS  <= HS_POL;
            vga_VS  <= VS_POL;
            display <= 1'b0;
            X       <= '0;
            Y       <= '0;
            sof     <= 1'b0;
            sol     <= 1'b0;
            vblank  <= 1'b0;
        end else if (en) begin
            vga_HS  <= hs_act_s ^ HS_POL;
            vga_VS  <= vs_act_s ^ VS_POL;
            display <= act_s;
            X       <= x_s;
            Y       <= y_s;
            sof     <= sof_s;
            sol     <= sol_s;
            vblank  <= (v_cnt_r >= CW'(V_ACTIVE));
        end else begin
            vga_HS  <= vga_HS;
            vga_VS  <= vga_VS;
            display <= display;
            X       <= X;
            Y       <= Y;
            sof     <= 1'b0;
            sol     <= 1'b0;
            vblank  <= vblank;
        end
    end

endmodule
